sd_seq_gen_prog: RTL
====================

# sd_seq_gen_prog

Programmable srdy/drdy traffic generator, the next generation of the sequence generator. It is driven by config ports instead of a blocking task, so it runs in simulation or on an FPGA bench. It emits a burst of N words with a programmable valid/gap pattern, and the payload is either incrementing or LFSR. It reports busy, a done pulse and a transfer count, and sits at the producer side of any srdy/drdy block under test.

## Interface
- width, 16: total p_data width.
- tag_sz, 4: upper tag field width; count_sz = width - tag_sz, and count_sz must be at least 2.
- pat_dep, 8: srdy gap pattern length in bits.
- lfsr_taps, {count_sz{1'b0}} | 'h3: feedback tap mask for the Fibonacci LFSR over count_sz bits.
- clk  in  1  clock; all logic is posedge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin a burst using the current cfg_* values.
- cfg_count  in  32  number of words in the burst.
- cfg_mode  in  1  payload mode: 0 = increment, 1 = LFSR.
- cfg_tag  in  tag_sz  tag value placed in p_data[width-1:count_sz].
- cfg_seed  in  count_sz  first payload value.
- cfg_pat  in  pat_dep  srdy pattern: bit i = 1 permits a valid at pattern slot i.
- p_srdy  out  1  producer valid, registered.
- p_drdy  in  1  consumer ready.
- p_data  out  width  {tag, payload}.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes.
- sent  out  32  words transferred in the current or last burst.

## Operation
- The state machine has two states, IDLE and RUN. Reset places it in IDLE.
- Reset values: p_srdy=0, busy=0, done=0, sent=0, payload=0, ptr=0, remaining=0.
- IDLE with start=1 and cfg_count≠0:
  - Latch count, mode, tag, seed (substituting 1 for a 0 seed in LFSR mode) and pat.
  - Clear sent and ptr.
  - Go to RUN; busy=1 from the next cycle.
- IDLE with start=1 and cfg_count=0: stay in IDLE, pulse done the next cycle, no transfers, sent=0.
- start in RUN is ignored. cfg_* changes in RUN have no effect.
- Transfer: p_srdy & p_drdy at a clock edge. Each transfer does remaining-1, sent+1, and advances the payload.
- Payload advance:
  - Increment mode: payload+1, mod 2^count_sz.
  - LFSR mode: shift left, with new LSB = XOR of payload & lfsr_taps.
- Hold rule: while p_srdy=1 and p_drdy=0, p_srdy, p_data and ptr are frozen.
- At every edge in RUN that is not a hold:
  - ptr advances as (ptr+1) mod pat_dep.
  - Next p_srdy = pat[ptr] if remaining after this edge > 0, else 0.
- Final transfer (remaining reaches 0): p_srdy=0, busy=0 and done=1 at the next cycle; state returns to IDLE.
- sent holds its final value until the next accepted start.
- p_srdy never falls without a transfer. The generator never drops or duplicates a payload value.

## Timing
- start sampled at edge N:
  - busy=1 after edge N.
  - First possible p_srdy=1 is after edge N+1, when pat[0]=1.
- All-ones pattern with p_drdy held at 1: one word per cycle. N words occupy N consecutive cycles.
- A pattern 0 bit inserts exactly one idle cycle at that slot.
- done is asserted in the cycle after the last transfer. A new start is accepted in that same cycle, since the state is already IDLE.
- Reset mid-burst: all outputs return to reset values at the next cycle and no done pulse is generated.

## Configuration
- SD_SEQ_GEN_PROG_XINVAL_EN
  - Defined: p_data = {width{1'bx}} whenever p_srdy=0, which exposes consumers that sample invalid data.
  - Undefined: p_data always shows {tag, current payload}.
- With either setting, p_data is identical whenever p_srdy=1.

## Test plan
- Increment mode, count=4, seed=0x010, tag=0x3, pat=all ones, p_drdy=1 → four consecutive words 0x3010..0x3013; done pulses 1 cycle after the last word; sent=4.
- pat=8'b01010101 (bit0=1), count=3, p_drdy=1 → p_srdy follows 1,0,1,0,1; values 0x..00..02 with no skips; busy falls with done.
- Backpressure: count=2, p_drdy held 0 for 5 cycles → p_srdy stays 1 and p_data stays at the first value for 5 cycles; then 2 transfers; sent=2.
- LFSR mode, seed=0, count=3, default taps, width=16 → first payload 0x001 (zero seed replaced), then each word is the LFSR step of the previous one; the bench model matches bit-exactly.
- Edge cases:
  - start with count=0 → done pulses once, p_srdy never rises.
  - start asserted during RUN → ignored, sent unaffected.
- Reset asserted mid-burst after 2 of 10 transfers → next cycle p_srdy=0, busy=0, sent=0, no done; a fresh start then works normally.

Source files
------------

// File: rtl/sd_seq_gen_prog.sv
// sd_seq_gen_prog -- programmable srdy/drdy traffic generator.
//
// Emits a burst of cfg_count words on a srdy/drdy producer port. A gap
// pattern (cfg_pat) decides which slots may carry a valid, and the payload
// is either an incrementing count or a Fibonacci LFSR. The tag field sits
// in the upper bits of every word.
//
// Optional build macro:
//   SD_SEQ_GEN_PROG_XINVAL_EN  drive p_data to X whenever p_srdy is low, so
//                              consumers that sample invalid data are caught.
//                              Undefined (default): p_data always shows
//                              {tag, current payload}.
//
// Ports:
//   clk, reset       posedge clock, synchronous active-high reset
//   start            one-cycle burst request (ignored while running)
//   cfg_count        words in the burst (0 = immediate done, no transfers)
//   cfg_mode         payload mode: 0 = increment, 1 = LFSR
//   cfg_tag          tag placed in p_data[width-1:count_sz]
//   cfg_seed         first payload value (0 becomes 1 in LFSR mode)
//   cfg_pat          srdy pattern, bit i permits a valid in slot i
//   p_srdy/p_drdy    producer valid / consumer ready
//   p_data           {tag, payload}
//   busy             burst in progress
//   done             one-cycle pulse after the final transfer
//   sent             words transferred in the current or last burst
module sd_seq_gen_prog #(
  parameter int width   = 16,
  parameter int tag_sz  = 4,
  parameter int pat_dep = 8,
  parameter logic [width-tag_sz-1:0] lfsr_taps = 'h3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               cfg_count,
  input  logic                      cfg_mode,
  input  logic [tag_sz-1:0]         cfg_tag,
  input  logic [width-tag_sz-1:0]   cfg_seed,
  input  logic [pat_dep-1:0]        cfg_pat,
  output logic                      p_srdy,
  input  logic                      p_drdy,
  output logic [width-1:0]          p_data,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               sent
);

  localparam int count_sz = width - tag_sz;
  localparam int ptr_w    = (pat_dep > 1) ? $clog2(pat_dep) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [count_sz-1:0]   payload;
  logic [ptr_w-1:0]      ptr;
  logic [31:0]           remaining;
  logic                  mode_r;
  logic [tag_sz-1:0]     tag_r;
  logic [pat_dep-1:0]    pat_r;

  logic                  xfer;
  logic                  hold;
  logic [31:0]           rem_next;
  logic [ptr_w-1:0]      ptr_next;

  // One payload step: increment wraps at 2^count_sz, LFSR shifts left
  // with the tap parity entering at the LSB.
  function automatic logic [count_sz-1:0] next_payload(
    input logic [count_sz-1:0] cur,
    input logic                lfsr
  );
    if (lfsr)
      return {cur[count_sz-2:0], ^(cur & lfsr_taps)};
    return cur + count_sz'(1);
  endfunction

  // A zero seed would lock the LFSR at zero forever.
  function automatic logic [count_sz-1:0] fix_seed(
    input logic [count_sz-1:0] seed,
    input logic                lfsr
  );
    if (lfsr && (seed == '0))
      return count_sz'(1);
    return seed;
  endfunction

  assign xfer     = p_srdy & p_drdy;
  assign hold     = p_srdy & ~p_drdy;
  assign rem_next = remaining - {31'd0, xfer};
  assign ptr_next = (ptr == ptr_w'(pat_dep - 1)) ? '0 : ptr + ptr_w'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      p_srdy    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent      <= '0;
      payload   <= '0;
      ptr       <= '0;
      remaining <= '0;
      mode_r    <= 1'b0;
      tag_r     <= '0;
      pat_r     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sent <= '0;
            ptr  <= '0;
            if (cfg_count != 32'd0) begin
              remaining <= cfg_count;
              mode_r    <= cfg_mode;
              tag_r     <= cfg_tag;
              pat_r     <= cfg_pat;
              payload   <= fix_seed(cfg_seed, cfg_mode);
              busy      <= 1'b1;
              state     <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          // A pending valid without ready freezes srdy, data and the slot.
          if (!hold) begin
            if (xfer) begin
              sent    <= sent + 32'd1;
              payload <= next_payload(payload, mode_r);
            end
            remaining <= rem_next;
            ptr       <= ptr_next;
            if (rem_next != 32'd0) begin
              p_srdy <= pat_r[ptr];
            end else begin
              p_srdy <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SD_SEQ_GEN_PROG_XINVAL_EN
  assign p_data = p_srdy ? {tag_r, payload} : {width{1'bx}};
`else
  assign p_data = {tag_r, payload};
`endif

endmodule
